ps2_key_gen: RTL and testbench



---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_filter.sv | 39 +++
 rtl/ps2_key_gen.sv | 128 ++++++++++++
 tb/tb_ps2_key_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: special scancode bytes and the frame-state encoding.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_REL    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_ERR0   = 8'hFC;
   localparam logic [7:0] PS2_RESEND = 8'hFE;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } frame_state_e;

   // Keyboard status/reply bytes that carry no key information on their own.
   function automatic logic is_status(input logic [7:0] b);
      return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) ||
             (b == PS2_ERR0) || (b == PS2_RESEND);
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for one PS/2 line; idle level is 1.
module ps2_line_filter #(
   parameter int unsigned FILTER = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic fall
);

   localparam int unsigned CW = (FILTER < 2) ? 1 : $clog2(FILTER);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // level flips on the FILTER-th consecutive synchronized sample that disagrees with it
   always_ff @(posedge clk) begin
      if (reset) begin
         sync  <= '1;
         level <= 1'b1;
         cnt   <= '0;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         fall <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER - 1)) begin
            level <= sync[1];
            fall  <= level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_key_gen.sv
// PS/2 device-to-host deframer and scancode decoder producing the
// toggle-flagged 11-bit key event word {toggle, pressed, ext, code}.
module ps2_key_gen
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER  = 8,
   parameter int unsigned TIMEOUT = 10000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        key_strobe,
   output logic        frame_err
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic         bit_edge;
   logic         data_bit;
   logic         clk_level_unused;
   logic         data_fall_unused;

   frame_state_e state;
   logic [2:0]   bitcnt;
   logic [7:0]   shreg;
   logic         par;
   logic [TW-1:0] to_cnt;
   logic         ext;
   logic         rel;
   logic [2:0]   skip;

   ps2_line_filter #(.FILTER(FILTER)) u_clk_filter (
      .clk   (clk_sys),
      .reset (reset),
      .raw   (ps2_clk),
      .level (clk_level_unused),
      .fall  (bit_edge)
   );

   ps2_line_filter #(.FILTER(FILTER)) u_data_filter (
      .clk   (clk_sys),
      .reset (reset),
      .raw   (ps2_data),
      .level (data_bit),
      .fall  (data_fall_unused)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         bitcnt     <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         to_cnt     <= '0;
         ext        <= 1'b0;
         rel        <= 1'b0;
         skip       <= '0;
         ps2_key    <= '0;
         key_strobe <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         key_strobe <= 1'b0;
         frame_err  <= 1'b0;
         if (state != IDLE)
            to_cnt <= to_cnt + TW'(1);

         if (bit_edge) begin
            // counting from 1 makes the error land exactly TIMEOUT cycles after the edge
            to_cnt <= TW'(1);
            unique case (state)
               IDLE: begin
                  if (!data_bit) begin
                     state  <= DATA;
                     bitcnt <= '0;
                  end
               end
               DATA: begin
                  shreg  <= {data_bit, shreg[7:1]};
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7)
                     state <= PARITY;
               end
               PARITY: begin
                  par   <= data_bit;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (data_bit && (^{shreg, par})) begin
                     if (skip != 3'd0) begin
                        skip <= skip - 3'd1;
                        if (skip == 3'd1) begin
                           ext <= 1'b0;
                           rel <= 1'b0;
                        end
                     end else if (shreg == PS2_EXT) begin
                        ext <= 1'b1;
                     end else if (shreg == PS2_REL) begin
                        rel <= 1'b1;
                     end else if (shreg == PS2_PAUSE) begin
                        skip <= 3'd7;
                     end else if (!(is_status(shreg) && !ext && !rel)) begin
                        ps2_key    <= {~ps2_key[10], ~rel, ext, shreg};
                        key_strobe <= 1'b1;
                        ext        <= 1'b0;
                        rel        <= 1'b0;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     ext       <= 1'b0;
                     rel       <= 1'b0;
                     skip      <= '0;
                  end
               end
            endcase
         end else if (state != IDLE && to_cnt == TW'(TIMEOUT - 1)) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            ext       <= 1'b0;
            rel       <= 1'b0;
            skip      <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_gen.sv
// Directed bench for ps2_key_gen: table of frames with expected events plus
// hand sequences for timeout, glitch rejection and mid-frame reset.
module tb_ps2_key_gen;

   localparam int unsigned FILTER  = 8;
   localparam int unsigned TIMEOUT = 10000;
   localparam int unsigned HALF    = 60;
   localparam int unsigned LAT     = FILTER + 3;

   typedef struct {
      logic [7:0]  b;
      bit          bad_par;
      logic        stop;
      int          gbit;
      bit          exp_strobe;
      bit          exp_err;
      logic [10:0] exp_key;
   } vec_t;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ps2_clk;
   logic        ps2_data;
   logic [10:0] ps2_key;
   logic        key_strobe;
   logic        frame_err;

   int unsigned cyc = 0;
   int unsigned drive_cyc = 0;
   int unsigned last_evt_cyc = 0;
   int          n_strobe = 0;
   int          n_err = 0;
   int          vectors = 0;
   int          miscompares = 0;
   vec_t        tbl[$];

   always #10 clk_sys = ~clk_sys;

   ps2_key_gen #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .ps2_key    (ps2_key),
      .key_strobe (key_strobe),
      .frame_err  (frame_err)
   );

   always @(posedge clk_sys) cyc <= cyc + 1;

   always @(negedge clk_sys) begin
      if (key_strobe) begin
         n_strobe++;
         last_evt_cyc = cyc;
      end
      if (frame_err) begin
         n_err++;
         last_evt_cyc = cyc;
      end
      if (key_strobe && frame_err) begin
         vectors++;
         miscompares++;
         $display("FAIL overlap: key_strobe=%0b frame_err=%0b, required not both high at cycle %0d",
                  key_strobe, frame_err, cyc);
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] b, input bit bp, input logic st, input int g,
                               input bit es, input bit ee, input logic [10:0] k);
      vec_t v;
      v.b = b; v.bad_par = bp; v.stop = st; v.gbit = g;
      v.exp_strobe = es; v.exp_err = ee; v.exp_key = k;
      return v;
   endfunction

   task automatic clock_bit(input logic b, input bit glitch);
      ps2_data = b;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk   = 1'b0;
      drive_cyc = cyc;
      repeat (HALF) @(negedge clk_sys);
      ps2_clk = 1'b1;
      if (glitch) begin
         repeat (3) begin
            repeat (20) @(negedge clk_sys);
            ps2_clk = 1'b0;
            repeat (FILTER - 1) @(negedge clk_sys);
            ps2_clk = 1'b1;
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                             input int gbit, input int nbits);
      logic [10:0] f;
      f = {stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++)
         clock_bit(f[i], i == gbit);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk_sys);
   endtask

   task automatic run_row(input int idx);
      vec_t v;
      v = tbl[idx];
      n_strobe = 0;
      n_err    = 0;
      send_frame(v.b, v.bad_par, v.stop, v.gbit, 11);
      check($sformatf("row%0d strobes", idx), n_strobe, int'(v.exp_strobe));
      check($sformatf("row%0d errors", idx), n_err, int'(v.exp_err));
      check($sformatf("row%0d ps2_key", idx), int'(ps2_key), int'(v.exp_key));
      if (v.exp_strobe || v.exp_err)
         check($sformatf("row%0d latency", idx), int'(last_evt_cyc - drive_cyc), int'(LAT));
   endtask

   initial begin
      // rows 0-10: prefixes, parity/stop errors, error clearing rel
      tbl.push_back(mk(8'h29, 0, 1, -1, 1, 0, 11'h629));
      tbl.push_back(mk(8'hE0, 0, 1, -1, 0, 0, 11'h629));
      tbl.push_back(mk(8'h74, 0, 1, -1, 1, 0, 11'h374));
      tbl.push_back(mk(8'hE0, 0, 1, -1, 0, 0, 11'h374));
      tbl.push_back(mk(8'hF0, 0, 1, -1, 0, 0, 11'h374));
      tbl.push_back(mk(8'h74, 0, 1, -1, 1, 0, 11'h574));
      tbl.push_back(mk(8'h1C, 1, 1, -1, 0, 1, 11'h574));
      tbl.push_back(mk(8'h1C, 0, 1, -1, 1, 0, 11'h21C));
      tbl.push_back(mk(8'h29, 0, 0, -1, 0, 1, 11'h21C));
      tbl.push_back(mk(8'hF0, 0, 1, -1, 0, 0, 11'h21C));
      tbl.push_back(mk(8'h1C, 1, 1, -1, 0, 1, 11'h21C));
      // rows 11-12: after reset, E0 74 / E0 F0 74 sequence
      tbl.push_back(mk(8'hE0, 0, 1, -1, 0, 0, 11'h000));
      tbl.push_back(mk(8'h74, 0, 1, -1, 1, 0, 11'h774));
      // rows 13-15
      tbl.push_back(mk(8'hE0, 0, 1, -1, 0, 0, 11'h774));
      tbl.push_back(mk(8'hF0, 0, 1, -1, 0, 0, 11'h774));
      tbl.push_back(mk(8'h74, 0, 1, -1, 1, 0, 11'h174));
      // rows 16-17: after timeout, then glitched frame
      tbl.push_back(mk(8'h16, 0, 1, -1, 1, 0, 11'h616));
      tbl.push_back(mk(8'h34, 0, 1,  4, 1, 0, 11'h234));
      // rows 18-26: pause sequence after mid-frame reset
      tbl.push_back(mk(8'hE1, 0, 1, -1, 0, 0, 11'h000));
      tbl.push_back(mk(8'h14, 0, 1, -1, 0, 0, 11'h000));
      tbl.push_back(mk(8'h77, 0, 1, -1, 0, 0, 11'h000));
      tbl.push_back(mk(8'hE1, 0, 1, -1, 0, 0, 11'h000));
      tbl.push_back(mk(8'hF0, 0, 1, -1, 0, 0, 11'h000));
      tbl.push_back(mk(8'h14, 0, 1, -1, 0, 0, 11'h000));
      tbl.push_back(mk(8'hF0, 0, 1, -1, 0, 0, 11'h000));
      tbl.push_back(mk(8'h77, 0, 1, -1, 0, 0, 11'h000));
      tbl.push_back(mk(8'h05, 0, 1, -1, 1, 0, 11'h605));
      // rows 27-35: status bytes dropped only without pending prefixes
      tbl.push_back(mk(8'hFA, 0, 1, -1, 0, 0, 11'h605));
      tbl.push_back(mk(8'hAA, 0, 1, -1, 0, 0, 11'h605));
      tbl.push_back(mk(8'hEE, 0, 1, -1, 0, 0, 11'h605));
      tbl.push_back(mk(8'hFE, 0, 1, -1, 0, 0, 11'h605));
      tbl.push_back(mk(8'hF0, 0, 1, -1, 0, 0, 11'h605));
      tbl.push_back(mk(8'hFA, 0, 1, -1, 1, 0, 11'h0FA));
      tbl.push_back(mk(8'hE0, 0, 1, -1, 0, 0, 11'h0FA));
      tbl.push_back(mk(8'hFC, 0, 1, -1, 1, 0, 11'h7FC));
      tbl.push_back(mk(8'hFC, 0, 1, -1, 0, 0, 11'h7FC));

      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(negedge clk_sys);
      check("reset ps2_key", int'(ps2_key), 0);
      check("reset key_strobe", int'(key_strobe), 0);
      check("reset frame_err", int'(frame_err), 0);
      reset = 1'b0;
      repeat (20) @(negedge clk_sys);

      for (int i = 0; i <= 10; i++) run_row(i);

      reset = 1'b1;
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
      repeat (20) @(negedge clk_sys);
      for (int i = 11; i <= 15; i++) run_row(i);

      // clock stalls after start + 4 data bits
      n_strobe = 0;
      n_err    = 0;
      send_frame(8'h16, 0, 1, -1, 5);
      repeat (12000) @(negedge clk_sys);
      check("timeout errors", n_err, 1);
      check("timeout strobes", n_strobe, 0);
      check("timeout latency", int'(last_evt_cyc - drive_cyc), int'(FILTER + 2 + TIMEOUT));
      check("timeout ps2_key", int'(ps2_key), 'h174);

      for (int i = 16; i <= 17; i++) run_row(i);

      // reset in the middle of a frame
      n_strobe = 0;
      n_err    = 0;
      send_frame(8'h29, 0, 1, -1, 5);
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      check("midreset ps2_key", int'(ps2_key), 0);
      check("midreset key_strobe", int'(key_strobe), 0);
      check("midreset frame_err", int'(frame_err), 0);
      reset = 1'b0;
      repeat (50) @(negedge clk_sys);
      check("midreset events", n_strobe + n_err, 0);

      for (int i = 18; i <= 35; i++) run_row(i);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
